// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
// Holds the FSM state encoding, the cause-flag bit positions and a counter width helper.
// No logic; imported by rst_sequencer and rst_seq_btn_filter.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam int CAUSE_POR  = 0;
  localparam int CAUSE_PLL  = 1;
  localparam int CAUSE_BTN  = 2;
  localparam int CAUSE_SOFT = 3;

  // Bits needed for a counter running 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rst_seq_btn_filter.sv
// Purpose: synchronize the async active-low push-button and produce btn_pressed.
// Latency: 2 edges of synchronizer, plus DEBOUNCE_CYCLES when RST_SEQ_DEBOUNCE_EN is defined.
// Backpressure: none; level in, level out. Optional feature macro: RST_SEQ_DEBOUNCE_EN.
module rst_seq_btn_filter
  import rst_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_rst_n,
  output logic btn_pressed
);

  logic [1:0] btn_sync;
  logic       btn_s;

  // Two-flop synchronizer; idles at the released (high) level out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync <= 2'b11;
    end else begin
      btn_sync <= {btn_sync[0], btn_rst_n};
    end
  end

  assign btn_s = btn_sync[1];

`ifdef RST_SEQ_DEBOUNCE_EN
  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0] deb_cnt;

  // Count consecutive cycles where the synced level disagrees with the filtered
  // output; any return to agreement (a toggle) restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt     <= '0;
      btn_pressed <= 1'b0;
    end else if (btn_pressed == !btn_s) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_MAX) begin
      btn_pressed <= !btn_s;
      deb_cnt     <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign btn_pressed = !btn_s;
`endif

endmodule

// File: rtl/rst_sequencer.sv
// Purpose: merge POR, PLL loss, button and soft reset; hold, then release staged resets in order.
// Latency: soft 1 edge, PLL 3 edges, button 3 edges (+debounce) to assert; HOLD_CYCLES then GAP_CYCLES per stage to release.
// Backpressure: none; all outputs are registered levels. Optional feature macro: RST_SEQ_DEBOUNCE_EN.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES      = 3,
  parameter int HOLD_CYCLES     = 16,
  parameter int GAP_CYCLES      = 8,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  btn_rst_n,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] rst_out_n,
  output logic                  seq_done,
  output logic [3:0]            rst_cause
);

  localparam int HW = cnt_w(HOLD_CYCLES);
  localparam int GW = cnt_w(GAP_CYCLES);
  localparam int SW = cnt_w(NUM_STAGES);

  localparam logic [HW-1:0]         HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0]         GAP_MAX  = GW'(GAP_CYCLES - 1);
  // Index held in stage_idx at the moment the final stage is released.
  localparam logic [SW-1:0]         LAST_IDX = SW'((NUM_STAGES > 1) ? NUM_STAGES - 2 : 0);
  localparam logic [NUM_STAGES-1:0] STAGE0   = NUM_STAGES'(1);

  logic [1:0]    pll_sync;
  logic          pll_locked_s;
  logic          pll_seen;
  logic          btn_pressed;
  logic          pll_loss;
  logic          fault_i;
  logic [3:0]    src;
  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [GW-1:0] gap_cnt;
  logic [SW-1:0] stage_idx;

  rst_seq_btn_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_filter (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_rst_n  (btn_rst_n),
    .btn_pressed(btn_pressed)
  );

  // PLL lock synchronizer (starts unlocked); pll_seen marks that lock was ever observed,
  // so the synchronizer filling after POR is not reported as a lock loss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_sync <= 2'b00;
      pll_seen <= 1'b0;
    end else begin
      pll_sync <= {pll_sync[0], pll_locked};
      if (pll_sync[1]) pll_seen <= 1'b1;
    end
  end

  assign pll_locked_s = pll_sync[1];
  assign pll_loss     = !pll_locked_s && pll_seen;
  assign fault_i      = !pll_locked_s || btn_pressed || soft_rst_req;

  // Per-cycle cause vector in rst_cause bit order; POR only ever comes from rst_n.
  always_comb begin
    src             = 4'b0000;
    src[CAUSE_PLL]  = pll_loss;
    src[CAUSE_BTN]  = btn_pressed;
    src[CAUSE_SOFT] = soft_rst_req;
  end

  // Sequencer FSM with registered outputs; a fault always wins over a release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      stage_idx <= '0;
      rst_out_n <= '0;
      seq_done  <= 1'b0;
      rst_cause <= 4'b0001;
    end else begin
      case (state)
        HOLD: begin
          rst_out_n <= '0;
          seq_done  <= 1'b0;
          rst_cause <= rst_cause | src;
          if (fault_i) begin
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_MAX) begin
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            stage_idx <= '0;
            rst_out_n <= STAGE0;
            if (NUM_STAGES == 1) begin
              state    <= RUN;
              seq_done <= 1'b1;
            end else begin
              state <= RELEASE;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        default: begin
          if (fault_i) begin
            state     <= HOLD;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            stage_idx <= '0;
            rst_out_n <= '0;
            seq_done  <= 1'b0;
            rst_cause <= src;
          end else if (state == RELEASE) begin
            if (gap_cnt == GAP_MAX) begin
              gap_cnt   <= '0;
              rst_out_n <= (rst_out_n << 1) | STAGE0;
              stage_idx <= stage_idx + 1'b1;
              if (stage_idx == LAST_IDX) begin
                state    <= RUN;
                seq_done <= 1'b1;
              end
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
